// File: rtl/ccr_unit_pkg.sv
// Purpose: shared flag indices and jump-condition encodings for the condition-code stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ccr_unit_pkg;

  localparam int FLAG_W = 3;

  // Bit positions inside the {C,N,Z} flag vector
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  typedef enum logic [1:0] {
    JMP_ALWAYS = 2'b00,
    JMP_Z      = 2'b01,
    JMP_N      = 2'b10,
    JMP_C      = 2'b11
  } jmp_cond_e;

endpackage

// File: rtl/ccr_stack.sv
// Purpose: LIFO of flag snapshots saved on interrupt entry and popped on RTI.
// Latency: push/pop take effect at the clock edge; top_dat is combinational from the stored entries.
// Backpressure: none; pushes when full are ignored, the caller must gate push/pop and report errors.
// Ports: clk, rst_n (async active-low); push/push_dat, pop; top_dat = most recent snapshot;
//        full, empty, cnt = number of snapshots held.
module ccr_stack
  import ccr_unit_pkg::*;
#(
  parameter int STACK_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic [FLAG_W-1:0]              push_dat,
  input  logic                           pop,
  output logic [FLAG_W-1:0]              top_dat,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(STACK_DEPTH):0]   cnt
);

  localparam int CNT_W = $clog2(STACK_DEPTH) + 1;
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [FLAG_W-1:0] mem [STACK_DEPTH];
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt_q == CNT_W'(STACK_DEPTH));
  assign empty   = (cnt_q == '0);
  assign cnt     = cnt_q;
  assign wr_idx  = IDX_W'(cnt_q);
  assign rd_idx  = IDX_W'(cnt_q - CNT_W'(1));
  assign top_dat = mem[rd_idx];

  // Pop wins if both are requested; a simultaneous push is discarded.
  assign do_pop  = pop & ~empty;
  assign do_push = push & ~pop & ~full;

  // Entry storage needs no reset: contents are only read while cnt_q says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (do_pop) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end else if (do_push) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ccr_unit.sv
// Purpose: condition-code register after the ALU: masked flag writes, SETC/CLRC, jump resolve+consume, interrupt save/restore.
// Latency: flags and stack update 1 cycle after inputs; o_jmp_taken is combinational from the registered flags.
// Backpressure: i_stall freezes flags and stack; dropped pushes / empty pops are reported as one-cycle pulses.
// Ports: i_clk, i_rst_n; ALU flags + i_flag_we mask; i_setc/i_clrc; i_jmp_valid/i_jmp_cond;
//        i_int_save/i_rti_restore; o_ccr {C,N,Z}, o_jmp_taken, o_stack_cnt, o_save_ovf, o_restore_err.
module ccr_unit
  import ccr_unit_pkg::*;
#(
  parameter int STACK_DEPTH = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_stall,
  input  logic                          i_alu_valid,
  input  logic                          i_alu_zero,
  input  logic                          i_alu_neg,
  input  logic                          i_alu_carry,
  input  logic [2:0]                    i_flag_we,
  input  logic                          i_setc,
  input  logic                          i_clrc,
  input  logic                          i_jmp_valid,
  input  logic [1:0]                    i_jmp_cond,
  input  logic                          i_int_save,
  input  logic                          i_rti_restore,
  output logic [FLAG_W-1:0]             o_ccr,
  output logic                          o_jmp_taken,
  output logic [$clog2(STACK_DEPTH):0]  o_stack_cnt,
  output logic                          o_save_ovf,
  output logic                          o_restore_err
);

  logic [FLAG_W-1:0] alu_flags;
  logic [FLAG_W-1:0] clr_mask;
  logic [FLAG_W-1:0] flags_nxt;
  logic [FLAG_W-1:0] stk_top;
  logic              stk_full;
  logic              stk_empty;
  logic              sel_flag;
  logic              do_push;
  logic              do_pop;
  logic              ovf_nxt;
  logic              err_nxt;
  jmp_cond_e         cond;

  assign alu_flags = {i_alu_carry, i_alu_neg, i_alu_zero};
  assign cond      = jmp_cond_e'(i_jmp_cond);

  // Jump decision looks only at the registered flags, so it never depends on this cycle's ALU result.
  always_comb begin
    sel_flag = 1'b1;
    clr_mask = '0;
    case (cond)
      JMP_Z:   sel_flag = o_ccr[FLAG_Z];
      JMP_N:   sel_flag = o_ccr[FLAG_N];
      JMP_C:   sel_flag = o_ccr[FLAG_C];
      default: sel_flag = 1'b1;
    endcase
    o_jmp_taken = i_jmp_valid & sel_flag;
    if (o_jmp_taken) begin
      case (cond)
        JMP_Z:   clr_mask[FLAG_Z] = 1'b1;
        JMP_N:   clr_mask[FLAG_N] = 1'b1;
        JMP_C:   clr_mask[FLAG_C] = 1'b1;
        default: clr_mask = '0;
      endcase
    end
  end

  // Next flags before any restore: consume < ALU write < SETC/CLRC. This is also the snapshot pushed.
  always_comb begin
    flags_nxt = o_ccr & ~clr_mask;
    for (int b = 0; b < FLAG_W; b++) begin
      if (i_alu_valid && i_flag_we[b]) begin
        flags_nxt[b] = alu_flags[b];
      end
    end
    if (i_setc) begin
      flags_nxt[FLAG_C] = 1'b1;
    end else if (i_clrc) begin
      flags_nxt[FLAG_C] = 1'b0;
    end
  end

  // Restore beats save in the same cycle: only the pop happens.
  assign do_pop  = ~i_stall & i_rti_restore & ~stk_empty;
  assign do_push = ~i_stall & i_int_save & ~i_rti_restore & ~stk_full;
  assign ovf_nxt = ~i_stall & i_int_save & ~i_rti_restore & stk_full;
  assign err_nxt = ~i_stall & i_rti_restore & stk_empty;

  ccr_stack #(
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .push     (do_push),
    .push_dat (flags_nxt),
    .pop      (do_pop),
    .top_dat  (stk_top),
    .full     (stk_full),
    .empty    (stk_empty),
    .cnt      (o_stack_cnt)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ccr         <= '0;
      o_save_ovf    <= 1'b0;
      o_restore_err <= 1'b0;
    end else begin
      o_save_ovf    <= ovf_nxt;
      o_restore_err <= err_nxt;
      if (!i_stall) begin
        o_ccr <= do_pop ? stk_top : flags_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ccr_unit.sv
module tb_ccr_unit;

  localparam int DEPTH = 2;
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic       clk;
  logic       rst_n;
  logic       stall, alu_valid, alu_zero, alu_neg, alu_carry;
  logic [2:0] flag_we;
  logic       setc, clrc, jmp_valid;
  logic [1:0] jmp_cond;
  logic       int_save, rti_restore;
  logic [2:0] ccr;
  logic       jmp_taken;
  logic [1:0] stack_cnt;
  logic       save_ovf, restore_err;

  int n_cmp = 0;
  int n_fail = 0;

  ccr_unit #(.STACK_DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_stall       (stall),
    .i_alu_valid   (alu_valid),
    .i_alu_zero    (alu_zero),
    .i_alu_neg     (alu_neg),
    .i_alu_carry   (alu_carry),
    .i_flag_we     (flag_we),
    .i_setc        (setc),
    .i_clrc        (clrc),
    .i_jmp_valid   (jmp_valid),
    .i_jmp_cond    (jmp_cond),
    .i_int_save    (int_save),
    .i_rti_restore (rti_restore),
    .o_ccr         (ccr),
    .o_jmp_taken   (jmp_taken),
    .o_stack_cnt   (stack_cnt),
    .o_save_ovf    (save_ovf),
    .o_restore_err (restore_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       av, z, n, c;
    bit [2:0] we;
    bit       setc, clrc, jv;
    bit [1:0] cond;
    bit       save, rti, stall;
    bit       e_tk;
    bit [2:0] e_ccr;
    bit [1:0] e_cnt;
    bit       e_ovf, e_err;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit av, input bit z, input bit n, input bit c, input bit [2:0] we,
                       input bit sc, input bit cc, input bit jv, input bit [1:0] cd,
                       input bit sv, input bit rt, input bit st);
    alu_valid = av; alu_zero = z; alu_neg = n; alu_carry = c; flag_we = we;
    setc = sc; clrc = cc; jmp_valid = jv; jmp_cond = cd;
    int_save = sv; rti_restore = rt; stall = st;
  endtask

  // Reference model state: flags plus a queue used as the snapshot stack
  logic [2:0] m_ccr;
  logic [2:0] m_stk [$];
  logic       m_ovf, m_err;

  function automatic bit model_taken(input logic [2:0] f, input bit jv, input bit [1:0] cd);
    if (!jv) return 1'b0;
    if (cd == 2'd0) return 1'b1;
    return f[int'(cd) - 1];
  endfunction

  // One clock of architectural behaviour
  task automatic model_step(input bit av, input bit z, input bit n, input bit c, input bit [2:0] we,
                            input bit sc, input bit cc, input bit jv, input bit [1:0] cd,
                            input bit sv, input bit rt, input bit st);
    logic [2:0] nf;
    logic [2:0] alu;
    alu = {c, n, z};
    nf = m_ccr;
    if (model_taken(m_ccr, jv, cd) && cd != 2'd0) nf[int'(cd) - 1] = 1'b0;
    for (int b = 0; b < 3; b++) if (av && we[b]) nf[b] = alu[b];
    if (sc) nf[2] = 1'b1;
    else if (cc) nf[2] = 1'b0;
    m_ovf = 1'b0;
    m_err = 1'b0;
    if (!st) begin
      if (rt) begin
        if (m_stk.size() > 0) m_ccr = m_stk.pop_back();
        else begin
          m_ccr = nf;
          m_err = 1'b1;
        end
      end else begin
        m_ccr = nf;
        if (sv) begin
          if (m_stk.size() < DEPTH) m_stk.push_back(nf);
          else m_ovf = 1'b1;
        end
      end
    end
  endtask

  initial begin
    // Directed vectors, applied from reset in order
    //           av z n c  we     sc cc jv cond   sv rt st | tk ccr     cnt ovf err
    tbl[0]  = '{H,H,H,L, 3'b111, L,L,L, 2'b00, L,L,L, L, 3'b011, 2'd0, L,L};
    tbl[1]  = '{L,L,L,L, 3'b000, L,L,H, 2'b01, L,L,L, H, 3'b010, 2'd0, L,L};
    tbl[2]  = '{H,H,L,L, 3'b001, L,L,L, 2'b00, L,L,L, L, 3'b011, 2'd0, L,L};
    tbl[3]  = '{H,H,L,L, 3'b001, L,L,H, 2'b01, L,L,L, H, 3'b011, 2'd0, L,L};
    tbl[4]  = '{H,L,L,H, 3'b000, L,L,L, 2'b00, L,L,L, L, 3'b011, 2'd0, L,L};
    tbl[5]  = '{H,L,L,L, 3'b100, H,H,L, 2'b00, L,L,L, L, 3'b111, 2'd0, L,L};
    tbl[6]  = '{H,L,L,L, 3'b011, L,L,L, 2'b00, L,L,L, L, 3'b100, 2'd0, L,L};
    tbl[7]  = '{L,L,L,L, 3'b000, L,H,L, 2'b00, L,L,L, L, 3'b000, 2'd0, L,L};
    tbl[8]  = '{H,H,H,H, 3'b111, L,L,H, 2'b11, L,L,L, L, 3'b111, 2'd0, L,L};
    tbl[9]  = '{L,L,L,L, 3'b000, L,L,H, 2'b00, L,L,L, H, 3'b111, 2'd0, L,L};
    tbl[10] = '{L,L,L,L, 3'b000, L,L,H, 2'b10, L,L,L, H, 3'b101, 2'd0, L,L};
    tbl[11] = '{L,L,L,L, 3'b000, L,L,L, 2'b00, H,L,L, L, 3'b101, 2'd1, L,L};
    tbl[12] = '{H,L,H,L, 3'b111, L,L,L, 2'b00, H,L,L, L, 3'b010, 2'd2, L,L};
    tbl[13] = '{H,H,H,H, 3'b111, L,L,L, 2'b00, H,L,L, L, 3'b111, 2'd2, H,L};
    tbl[14] = '{L,L,L,L, 3'b000, L,L,L, 2'b00, L,L,L, L, 3'b111, 2'd2, L,L};
    tbl[15] = '{L,L,L,L, 3'b000, L,L,L, 2'b00, L,H,L, L, 3'b010, 2'd1, L,L};
    tbl[16] = '{L,L,L,L, 3'b000, L,L,L, 2'b00, L,H,L, L, 3'b101, 2'd0, L,L};
    tbl[17] = '{L,L,L,L, 3'b000, L,L,L, 2'b00, L,H,L, L, 3'b101, 2'd0, L,H};
    tbl[18] = '{L,L,L,L, 3'b000, L,L,L, 2'b00, L,L,L, L, 3'b101, 2'd0, L,L};
    tbl[19] = '{H,L,L,L, 3'b111, L,L,H, 2'b01, H,L,H, H, 3'b101, 2'd0, L,L};
    tbl[20] = '{L,L,L,L, 3'b000, L,L,H, 2'b10, L,L,H, L, 3'b101, 2'd0, L,L};
    tbl[21] = '{L,L,L,L, 3'b000, L,L,L, 2'b00, H,L,L, L, 3'b101, 2'd1, L,L};
    tbl[22] = '{H,L,L,L, 3'b111, L,L,L, 2'b00, H,H,L, L, 3'b101, 2'd0, L,L};
    tbl[23] = '{L,L,L,L, 3'b000, L,L,L, 2'b00, L,H,H, L, 3'b101, 2'd0, L,L};

    drive(L,L,L,L,3'b000,L,L,L,2'b00,L,L,L);
    rst_n = 1'b0;
    #2;
    chk("reset_ccr", 32'(ccr), 32'h0);
    chk("reset_cnt", 32'(stack_cnt), 32'h0);
    chk("reset_ovf", 32'(save_ovf), 32'h0);
    chk("reset_err", 32'(restore_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      vec_t v;
      string tag;
      v = tbl[i];
      @(negedge clk);
      drive(v.av, v.z, v.n, v.c, v.we, v.setc, v.clrc, v.jv, v.cond, v.save, v.rti, v.stall);
      #1;
      tag = $sformatf("vec%0d", i);
      chk({tag, "_taken"}, 32'(jmp_taken), 32'(v.e_tk));
      @(posedge clk);
      #1;
      chk({tag, "_ccr"}, 32'(ccr), 32'(v.e_ccr));
      chk({tag, "_cnt"}, 32'(stack_cnt), 32'(v.e_cnt));
      chk({tag, "_ovf"}, 32'(save_ovf), 32'(v.e_ovf));
      chk({tag, "_err"}, 32'(restore_err), 32'(v.e_err));
    end

    // Asynchronous reset between edges with flags 111 and one snapshot held
    @(negedge clk);
    drive(H,H,H,H,3'b111,L,L,L,2'b00,H,L,L);
    @(posedge clk);
    #1;
    chk("pre_arst_ccr", 32'(ccr), 32'h7);
    chk("pre_arst_cnt", 32'(stack_cnt), 32'h1);
    drive(L,L,L,L,3'b000,L,L,L,2'b00,L,L,L);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_ccr", 32'(ccr), 32'h0);
    chk("arst_cnt", 32'(stack_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised run against the reference model
    m_ccr = 3'b000;
    m_stk.delete();
    for (int k = 0; k < 600; k++) begin
      bit av, z, n, c, sc, cc, jv, sv, rt, st;
      bit [2:0] we;
      bit [1:0] cd;
      bit etk;
      av = 1'($urandom_range(0, 1));
      z  = 1'($urandom_range(0, 1));
      n  = 1'($urandom_range(0, 1));
      c  = 1'($urandom_range(0, 1));
      we = 3'($urandom_range(0, 7));
      sc = ($urandom_range(0, 5) == 0);
      cc = ($urandom_range(0, 5) == 0);
      jv = ($urandom_range(0, 2) == 0);
      cd = 2'($urandom_range(0, 3));
      sv = ($urandom_range(0, 3) == 0);
      rt = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 7) == 0);
      if (sv && rt && m_stk.size() == 0) sv = 1'b0;
      @(negedge clk);
      drive(av, z, n, c, we, sc, cc, jv, cd, sv, rt, st);
      etk = model_taken(m_ccr, jv, cd);
      #1;
      chk("rnd_taken", 32'(jmp_taken), 32'(etk));
      model_step(av, z, n, c, we, sc, cc, jv, cd, sv, rt, st);
      @(posedge clk);
      #1;
      chk("rnd_ccr", 32'(ccr), 32'(m_ccr));
      chk("rnd_cnt", 32'(stack_cnt), 32'(m_stk.size()));
      chk("rnd_ovf", 32'(save_ovf), 32'(m_ovf));
      chk("rnd_err", 32'(restore_err), 32'(m_err));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
